// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame link (sender and receiver).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_frame_pkg;

    localparam int          LEN_W      = 8;
    localparam int          SYNC_W_DEF = 4;
    localparam logic [3:0]  SYNC_DEF   = 4'b1101;
    localparam int          FETCH_W    = LEN_W - 2;   // holds ceil(255/8) = 32

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_LEN,
        ST_PAYLOAD,
        ST_DONE
    } state_e;

    // Number of payload bytes needed to carry l bits.
    function automatic logic [FETCH_W-1:0] bytes_for_len(input logic [LEN_W-1:0] l);
        logic [LEN_W:0] s;
        s = {1'b0, l} + (LEN_W + 1)'(7);
        return s[LEN_W:3];
    endfunction

endpackage

// File: rtl/serial_frame_sender_if.sv
// Frame request, byte source handshake and serial line of the frame sender.
// Latency: n/a (wiring only).
// Backpressure: data_valid/data_ready on the byte source; start is a level request.
interface serial_frame_sender_if;
    import serial_frame_pkg::*;

    logic             start;
    logic [LEN_W-1:0] len;
    logic [7:0]       data_in;
    logic             data_valid;
    logic             data_ready;
    logic             serout;
    logic             busy;
    logic             done;
    logic             underrun;

    modport master (
        output start, len, data_in, data_valid,
        input  data_ready, serout, busy, done, underrun
    );

    modport slave (
        input  start, len, data_in, data_valid,
        output data_ready, serout, busy, done, underrun
    );

endinterface

// File: rtl/piso_shift8.sv
// 8-bit parallel-in serial-out shifter, MSB first.
// Latency: loaded byte's MSB on dout the cycle after load.
// Backpressure: none; load has priority over shift.
module piso_shift8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] load_dat,
    output logic       dout
);

    logic [7:0] sh_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_q <= '0;
        end else if (load) begin
            sh_q <= load_dat;
        end else if (shift) begin
            sh_q <= {sh_q[6:0], 1'b0};
        end
    end

    assign dout = sh_q[7];

endmodule

// File: rtl/serial_frame_sender.sv
// Serial frame sender: sync pattern, 8-bit length, then len payload bits MSB-first.
// Latency: first sync bit on serout the cycle after start is sampled; all outputs registered.
// Backpressure: one-byte buffer pulls via data_ready; a missing byte at a load point sends zeros and pulses underrun.
module serial_frame_sender
    import serial_frame_pkg::*;
#(
    parameter int                SYNC_W = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC   = SYNC_W'(SYNC_DEF)
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_frame_sender_if.slave bus
);

    localparam int CW = (SYNC_W > 8) ? $clog2(SYNC_W) : 3;

    state_e             state_q, state_nxt;
    logic [CW-1:0]      bit_cnt_q, bit_cnt_nxt;
    logic [LEN_W-1:0]   pay_cnt_q, pay_cnt_nxt;
    logic [LEN_W-1:0]   len_q, len_nxt;
    logic [FETCH_W-1:0] fetch_q, fetch_nxt;
    logic [7:0]         buf_q, buf_nxt;
    logic               buf_full_q, buf_full_nxt;
    logic               serout_q, serout_nxt;
    logic               busy_q, busy_nxt;
    logic               done_q, done_nxt;
    logic               ready_q, ready_nxt;
    logic               underrun_q, underrun_nxt;

    logic               hs;
    logic               load_pt;
    logic               shift_en;
    logic [7:0]         ld_byte;
    logic [SYNC_W-1:0]  sync_sh;
    logic [7:0]         len_sh;
    logic               piso_dout;

    // The MSB of each byte leaves through serout_q directly, so the shifter
    // is loaded already advanced by one bit and supplies the following bits.
    piso_shift8 u_piso (
        .clk      (clk),
        .rst      (rst),
        .load     (load_pt),
        .shift    (shift_en),
        .load_dat ({ld_byte[6:0], 1'b0}),
        .dout     (piso_dout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            pay_cnt_q  <= '0;
            len_q      <= '0;
            fetch_q    <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            serout_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            bit_cnt_q  <= bit_cnt_nxt;
            pay_cnt_q  <= pay_cnt_nxt;
            len_q      <= len_nxt;
            fetch_q    <= fetch_nxt;
            buf_q      <= buf_nxt;
            buf_full_q <= buf_full_nxt;
            serout_q   <= serout_nxt;
            busy_q     <= busy_nxt;
            done_q     <= done_nxt;
            ready_q    <= ready_nxt;
            underrun_q <= underrun_nxt;
        end
    end

    always_comb begin
        state_nxt    = state_q;
        bit_cnt_nxt  = bit_cnt_q;
        pay_cnt_nxt  = pay_cnt_q;
        len_nxt      = len_q;
        fetch_nxt    = fetch_q;
        buf_nxt      = buf_q;
        buf_full_nxt = buf_full_q;
        load_pt      = 1'b0;
        shift_en     = 1'b0;
        serout_nxt   = 1'b0;
        hs           = bus.data_valid && ready_q;
        ld_byte      = buf_full_q ? buf_q : 8'h00;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt   = ST_SYNC;
                    bit_cnt_nxt = '0;
                    len_nxt     = bus.len;
                    fetch_nxt   = bytes_for_len(bus.len);
                end
            end
            ST_SYNC: begin
                if (bit_cnt_q == CW'(SYNC_W - 1)) begin
                    state_nxt   = ST_LEN;
                    bit_cnt_nxt = '0;
                end else begin
                    bit_cnt_nxt = bit_cnt_q + CW'(1);
                end
            end
            ST_LEN: begin
                if (bit_cnt_q == CW'(7)) begin
                    bit_cnt_nxt = '0;
                    if (len_q != '0) begin
                        state_nxt   = ST_PAYLOAD;
                        pay_cnt_nxt = len_q - LEN_W'(1);
                        load_pt     = 1'b1;
                    end else begin
                        state_nxt   = ST_DONE;
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt_q + CW'(1);
                end
            end
            ST_PAYLOAD: begin
                // pay_cnt_q counts bits still to send after the current one
                if (pay_cnt_q == '0) begin
                    state_nxt = ST_DONE;
                end else begin
                    pay_cnt_nxt = pay_cnt_q - LEN_W'(1);
                    if (bit_cnt_q == CW'(7)) begin
                        bit_cnt_nxt = '0;
                        load_pt     = 1'b1;
                    end else begin
                        bit_cnt_nxt = bit_cnt_q + CW'(1);
                        shift_en    = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (hs) begin
            buf_nxt   = bus.data_in;
            fetch_nxt = fetch_nxt - FETCH_W'(1);
        end

        // An empty buffer at a load point still consumes that byte's fetch slot.
        if (load_pt) begin
            buf_full_nxt = hs;
            if (!buf_full_q && fetch_nxt != '0) begin
                fetch_nxt = fetch_nxt - FETCH_W'(1);
            end
        end else if (hs) begin
            buf_full_nxt = 1'b1;
        end

        if (state_nxt == ST_IDLE || state_nxt == ST_DONE) begin
            buf_full_nxt = 1'b0;
        end

        sync_sh = SYNC << bit_cnt_nxt;
        len_sh  = len_nxt << bit_cnt_nxt[2:0];

        case (state_nxt)
            ST_SYNC:    serout_nxt = sync_sh[SYNC_W-1];
            ST_LEN:     serout_nxt = len_sh[7];
            ST_PAYLOAD: serout_nxt = load_pt ? ld_byte[7] : piso_dout;
            default:    serout_nxt = 1'b0;
        endcase

        ready_nxt    = !buf_full_nxt && (fetch_nxt != '0) &&
                       (state_nxt == ST_SYNC || state_nxt == ST_LEN || state_nxt == ST_PAYLOAD);
        busy_nxt     = (state_nxt != ST_IDLE);
        done_nxt     = (state_nxt == ST_DONE);
        underrun_nxt = load_pt && !buf_full_q;
    end

    assign bus.data_ready = ready_q;
    assign bus.serout     = serout_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.underrun   = underrun_q;

endmodule

// File: tb/tb_serial_frame_sender.sv
// Scoreboard bench for serial_frame_sender: expected line bits queued per frame, checked by a monitor.
module tb_serial_frame_sender;
    import serial_frame_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_frame_sender_if bus ();

    serial_frame_sender #(
        .SYNC_W (SYNC_W_DEF),
        .SYNC   (SYNC_DEF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         tests = 0;
    int         fails = 0;
    int         hs_cnt = 0;
    bit         ready_seen = 1'b0;
    logic [2:0] exp_q[$];     // {serout, done, underrun} per busy cycle
    logic [7:0] src_q[$];
    logic [2:0] e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bytes at index >= npres are never supplied: zeros with underrun on their first bit.
    task automatic push_frame(input logic [7:0] l, input logic [7:0] b0,
                              input logic [7:0] b1, input int npres);
        logic [SYNC_W_DEF-1:0] s;
        logic [7:0]            by;
        bit                    pres;
        s = SYNC_DEF;
        for (int i = SYNC_W_DEF - 1; i >= 0; i--) exp_q.push_back({s[i], 2'b00});
        for (int i = 7; i >= 0; i--) exp_q.push_back({l[i], 2'b00});
        for (int p = 0; p < int'(l); p++) begin
            pres = (p / 8) < npres;
            by   = (p / 8 == 0) ? b0 : b1;
            if (!pres) by = 8'h00;
            exp_q.push_back({by[7 - (p % 8)], 1'b0, (p % 8 == 0) && !pres});
        end
        exp_q.push_back(3'b010);
    endtask

    task automatic start_frame(input logic [7:0] l);
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = l;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s: done not seen within 300 cycles", name);
        end
    endtask

    // Monitor: every busy cycle must match the next queued expectation.
    always @(negedge clk) begin
        if (rst && bus.data_ready) ready_seen = 1'b1;
        if (rst && bus.busy) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_empty: got serout/done/underrun %b%b%b, expected nothing (idle)",
                         bus.serout, bus.done, bus.underrun);
            end else begin
                e = exp_q.pop_front();
                check("line", {29'd0, bus.serout, bus.done, bus.underrun}, {29'd0, e});
            end
        end
    end

    // Byte source: offers the head of src_q until it is taken.
    initial begin
        bus.data_valid = 1'b0;
        bus.data_in    = 8'h00;
        forever begin
            @(posedge clk);
            if (bus.data_valid && bus.data_ready && src_q.size() != 0) begin
                void'(src_q.pop_front());
                hs_cnt++;
            end
            #1;
            bus.data_valid = (src_q.size() != 0);
            bus.data_in    = (src_q.size() != 0) ? src_q[0] : 8'h00;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.len   = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_serout",   bus.serout,     0);
        check("rst_busy",     bus.busy,       0);
        check("rst_done",     bus.done,       0);
        check("rst_ready",    bus.data_ready, 0);
        check("rst_underrun", bus.underrun,   0);
        @(negedge clk);
        rst = 1'b1;

        // len=0: sync + zero length, no byte requests
        ready_seen = 1'b0;
        hs_cnt = 0;
        push_frame(8'd0, 8'h00, 8'h00, 0);
        start_frame(8'd0);
        wait_done("len0_done");
        @(negedge clk);
        check("len0_no_ready", ready_seen, 0);
        check("len0_hs", hs_cnt, 0);
        check("len0_sb_drain", exp_q.size(), 0);

        // len=8, byte arrives during LEN
        hs_cnt = 0;
        push_frame(8'd8, 8'hA5, 8'h00, 1);
        start_frame(8'd8);
        repeat (SYNC_W_DEF) @(negedge clk);
        src_q.push_back(8'hA5);
        wait_done("len8_done");
        @(negedge clk);
        check("len8_hs", hs_cnt, 1);
        check("len8_sb_drain", exp_q.size(), 0);

        // len=11: two bytes, third offered byte must never be taken
        hs_cnt = 0;
        src_q.push_back(8'hF0);
        src_q.push_back(8'hE0);
        src_q.push_back(8'h77);
        push_frame(8'd11, 8'hF0, 8'hE0, 2);
        start_frame(8'd11);
        wait_done("len11_done");
        @(negedge clk);
        check("len11_hs", hs_cnt, 2);
        check("len11_left", src_q.size(), 1);
        check("len11_sb_drain", exp_q.size(), 0);
        src_q.delete();
        repeat (2) @(negedge clk);

        // len=16, second byte withheld: zeros plus underrun at bit 9
        hs_cnt = 0;
        src_q.push_back(8'h3C);
        push_frame(8'd16, 8'h3C, 8'h00, 1);
        start_frame(8'd16);
        wait_done("len16_done");
        @(negedge clk);
        check("len16_hs", hs_cnt, 1);
        check("len16_sb_drain", exp_q.size(), 0);

        // start held: back-to-back frames, len change mid-frame only hits the next one
        hs_cnt = 0;
        src_q.push_back(8'hC3);
        push_frame(8'd8, 8'hC3, 8'h00, 1);
        push_frame(8'd0, 8'h00, 8'h00, 0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = 8'd8;
        repeat (6) @(negedge clk);
        bus.len = 8'd0;
        wait_done("b2b_first_done");
        @(negedge clk);
        check("b2b_gap_idle", bus.busy, 0);
        @(negedge clk);
        check("b2b_gap_restart", bus.busy, 1);
        bus.start = 1'b0;
        wait_done("b2b_second_done");
        repeat (3) @(negedge clk);
        check("b2b_stopped", bus.busy, 0);
        check("b2b_hs", hs_cnt, 1);
        check("b2b_sb_drain", exp_q.size(), 0);

        // reset during LEN of a len=40 frame, then a clean len=8 frame
        src_q.push_back(8'h3C);
        push_frame(8'd40, 8'h3C, 8'h00, 1);
        start_frame(8'd40);
        repeat (SYNC_W_DEF + 2) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_serout",   bus.serout,     0);
        check("mid_rst_busy",     bus.busy,       0);
        check("mid_rst_done",     bus.done,       0);
        check("mid_rst_ready",    bus.data_ready, 0);
        check("mid_rst_underrun", bus.underrun,   0);
        exp_q.delete();
        src_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        hs_cnt = 0;
        src_q.push_back(8'h5A);
        push_frame(8'd8, 8'h5A, 8'h00, 1);
        start_frame(8'd8);
        wait_done("post_rst_done");
        @(negedge clk);
        check("post_rst_hs", hs_cnt, 1);
        check("post_rst_sb_drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
